// File: rtl/alu_share_arbiter_pkg.sv
// rtl/alu_share_arbiter_pkg.sv - shared types and constants for the ALU share arbiter
// FSM encodings, ALU function codes and width defaults used by the arbiter, ALU and control unit.
package alu_share_arbiter_pkg;

  localparam int DATA_WIDTH_DEF = 16;
  localparam int FUNC_WIDTH_DEF = 4;
  localparam int STAT_WIDTH     = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Function codes understood by the shared ALU.
  localparam logic [FUNC_WIDTH_DEF-1:0] ALU_ADD   = 4'h0;
  localparam logic [FUNC_WIDTH_DEF-1:0] ALU_SUB   = 4'h1;
  localparam logic [FUNC_WIDTH_DEF-1:0] ALU_AND   = 4'h2;
  localparam logic [FUNC_WIDTH_DEF-1:0] ALU_OR    = 4'h3;
  localparam logic [FUNC_WIDTH_DEF-1:0] ALU_XOR   = 4'h4;
  localparam logic [FUNC_WIDTH_DEF-1:0] ALU_NOT   = 4'h5;
  localparam logic [FUNC_WIDTH_DEF-1:0] ALU_SHL   = 4'h6;
  localparam logic [FUNC_WIDTH_DEF-1:0] ALU_SHR   = 4'h7;
  localparam logic [FUNC_WIDTH_DEF-1:0] ALU_PASSA = 4'h8;
  localparam logic [FUNC_WIDTH_DEF-1:0] ALU_PASSB = 4'h9;

  function automatic logic [STAT_WIDTH-1:0] sat_inc(input logic [STAT_WIDTH-1:0] v);
    return (v == {STAT_WIDTH{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/alu_share_arbiter_rr_arb2.sv
// rtl/alu_share_arbiter_rr_arb2.sv - combinational two-way round-robin arbiter
// A lone valid requester always wins; on contention the one not granted last wins.
module rr_arb2 (
  input  logic valid0,
  input  logic valid1,
  input  logic last_grant,
  output logic gnt0,
  output logic gnt1,
  output logic gnt_id
);

  always_comb begin
    gnt0   = 1'b0;
    gnt1   = 1'b0;
    gnt_id = 1'b0;
    if (valid0 && valid1) begin
      gnt0   = last_grant;
      gnt1   = ~last_grant;
      gnt_id = ~last_grant;
    end else if (valid1) begin
      gnt1   = 1'b1;
      gnt_id = 1'b1;
    end else if (valid0) begin
      gnt0   = 1'b1;
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - shares one combinational ALU between two requesters
// Optional grant/overflow statistics are built when ALU_SHARE_ARBITER_STATS_EN is defined.
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int FUNC_WIDTH = FUNC_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [DATA_WIDTH-1:0] req0_a,
  input  logic [DATA_WIDTH-1:0] req0_b,
  input  logic [FUNC_WIDTH-1:0] req0_func,
  output logic                  resp0_valid,
  input  logic                  resp0_ready,
  output logic [DATA_WIDTH-1:0] resp0_c,
  output logic                  resp0_ovf,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [DATA_WIDTH-1:0] req1_a,
  input  logic [DATA_WIDTH-1:0] req1_b,
  input  logic [FUNC_WIDTH-1:0] req1_func,
  output logic                  resp1_valid,
  input  logic                  resp1_ready,
  output logic [DATA_WIDTH-1:0] resp1_c,
  output logic                  resp1_ovf,
`ifdef ALU_SHARE_ARBITER_STATS_EN
  output logic [STAT_WIDTH-1:0] grant_cnt0,
  output logic [STAT_WIDTH-1:0] grant_cnt1,
  output logic [STAT_WIDTH-1:0] ovf_cnt,
`endif
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  output logic [FUNC_WIDTH-1:0] alu_func,
  input  logic [DATA_WIDTH-1:0] alu_c,
  input  logic                  alu_ovf
);

  state_e                state_q, state_d;
  logic                  last_grant_q;
  logic                  owner_q;
  logic [DATA_WIDTH-1:0] op_a_q, op_b_q;
  logic [FUNC_WIDTH-1:0] op_func_q;
  logic [DATA_WIDTH-1:0] res_c_q;
  logic                  res_ovf_q;

  logic gnt0, gnt1, gnt_id;
  logic accept;
  logic capture;

  rr_arb2 u_arb (
    .valid0     (req0_valid),
    .valid1     (req1_valid),
    .last_grant (last_grant_q),
    .gnt0       (gnt0),
    .gnt1       (gnt1),
    .gnt_id     (gnt_id)
  );

  // Handshakes and response valids are suppressed while reset is held so a
  // dropped operation can never leak a response or be half-accepted.
  always_comb begin
    state_d     = state_q;
    accept      = 1'b0;
    capture     = 1'b0;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    resp0_valid = 1'b0;
    resp1_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req0_ready = gnt0 & ~reset;
        req1_ready = gnt1 & ~reset;
        accept     = req0_ready | req1_ready;
        if (accept) begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        capture = 1'b1;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        resp0_valid = ~owner_q & ~reset;
        resp1_valid = owner_q & ~reset;
        if (owner_q ? resp1_ready : resp0_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      op_func_q    <= '0;
      res_c_q      <= '0;
      res_ovf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        owner_q      <= gnt_id;
        last_grant_q <= gnt_id;
        op_a_q       <= gnt_id ? req1_a : req0_a;
        op_b_q       <= gnt_id ? req1_b : req0_b;
        op_func_q    <= gnt_id ? req1_func : req0_func;
      end
      if (capture) begin
        res_c_q   <= alu_c;
        res_ovf_q <= alu_ovf;
      end
    end
  end

  assign alu_a     = op_a_q;
  assign alu_b     = op_b_q;
  assign alu_func  = op_func_q;

  assign resp0_c   = res_c_q;
  assign resp0_ovf = res_ovf_q;
  assign resp1_c   = res_c_q;
  assign resp1_ovf = res_ovf_q;

`ifdef ALU_SHARE_ARBITER_STATS_EN
  logic [STAT_WIDTH-1:0] grant_cnt0_q, grant_cnt1_q, ovf_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      grant_cnt0_q <= '0;
      grant_cnt1_q <= '0;
      ovf_cnt_q    <= '0;
    end else begin
      if (accept && !gnt_id) begin
        grant_cnt0_q <= sat_inc(grant_cnt0_q);
      end
      if (accept && gnt_id) begin
        grant_cnt1_q <= sat_inc(grant_cnt1_q);
      end
      if (capture && alu_ovf) begin
        ovf_cnt_q <= sat_inc(ovf_cnt_q);
      end
    end
  end

  assign grant_cnt0 = grant_cnt0_q;
  assign grant_cnt1 = grant_cnt1_q;
  assign ovf_cnt    = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - directed self-checking bench for alu_share_arbiter
// Statistics checks are included when ALU_SHARE_ARBITER_STATS_EN is defined.
module tb_alu_share_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_ready, resp0_valid, resp0_ready, resp0_ovf;
  logic [15:0] req0_a, req0_b, resp0_c;
  logic [3:0]  req0_func;
  logic        req1_valid, req1_ready, resp1_valid, resp1_ready, resp1_ovf;
  logic [15:0] req1_a, req1_b, resp1_c;
  logic [3:0]  req1_func;
  logic [15:0] alu_a, alu_b, alu_c;
  logic [3:0]  alu_func;
  logic        alu_ovf;
`ifdef ALU_SHARE_ARBITER_STATS_EN
  logic [15:0] grant_cnt0, grant_cnt1, ovf_cnt;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  alu_share_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_a      (req0_a),
    .req0_b      (req0_b),
    .req0_func   (req0_func),
    .resp0_valid (resp0_valid),
    .resp0_ready (resp0_ready),
    .resp0_c     (resp0_c),
    .resp0_ovf   (resp0_ovf),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_a      (req1_a),
    .req1_b      (req1_b),
    .req1_func   (req1_func),
    .resp1_valid (resp1_valid),
    .resp1_ready (resp1_ready),
    .resp1_c     (resp1_c),
    .resp1_ovf   (resp1_ovf),
`ifdef ALU_SHARE_ARBITER_STATS_EN
    .grant_cnt0  (grant_cnt0),
    .grant_cnt1  (grant_cnt1),
    .ovf_cnt     (ovf_cnt),
`endif
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_func    (alu_func),
    .alu_c       (alu_c),
    .alu_ovf     (alu_ovf)
  );

  // Stand-in for the shared ALU: 0=ADD 1=SUB 2=AND 3=OR, signed overflow on ADD/SUB.
  always_comb begin
    alu_c   = 16'h0000;
    alu_ovf = 1'b0;
    case (alu_func)
      4'h0: begin
        alu_c   = alu_a + alu_b;
        alu_ovf = (alu_a[15] == alu_b[15]) && (alu_c[15] != alu_a[15]);
      end
      4'h1: begin
        alu_c   = alu_a - alu_b;
        alu_ovf = (alu_a[15] != alu_b[15]) && (alu_c[15] != alu_a[15]);
      end
      4'h2: alu_c = alu_a & alu_b;
      4'h3: alu_c = alu_a | alu_b;
      default: alu_c = 16'h0000;
    endcase
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
    for (int i = 0; i < 10; i++) begin
      tests_run++;
      if ({req0_ready, req1_ready, resp0_valid, resp1_valid} !== 4'b0000 ||
          alu_a !== 16'h0000 || alu_b !== 16'h0000 || alu_func !== 4'h0) begin
        tests_failed++;
        $display("FAIL reset_idle cyc%0d: rdy=%b%b vld=%b%b a=%h b=%h f=%h, want all 0",
                 i, req0_ready, req1_ready, resp0_valid, resp1_valid, alu_a, alu_b, alu_func);
      end
      tick();
    end
  endtask

  task automatic test_single_add;
    req0_a = 16'h0003; req0_b = 16'h0004; req0_func = 4'h0;
    req0_valid = 1'b1; resp0_ready = 1'b1;
    #1;
    tests_run++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_accept: rdy0=%b rdy1=%b, want 1 0", req0_ready, req1_ready);
    end
    tick();
    req0_valid = 1'b0;
    #1;
    tests_run++;
    if (resp0_valid !== 1'b0 || req0_ready !== 1'b0 || alu_a !== 16'h0003 || alu_b !== 16'h0004) begin
      tests_failed++;
      $display("FAIL single_exec: vld0=%b rdy0=%b a=%h b=%h, want 0 0 0003 0004",
               resp0_valid, req0_ready, alu_a, alu_b);
    end
    tick();
    tests_run++;
    if (resp0_valid !== 1'b1 || resp1_valid !== 1'b0 || resp0_c !== 16'h0007 || resp0_ovf !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_resp: vld0=%b vld1=%b c=%h ovf=%b, want 1 0 0007 0",
               resp0_valid, resp1_valid, resp0_c, resp0_ovf);
    end
    tick();
    tests_run++;
    if (resp0_valid !== 1'b0 || resp1_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_done: vld0=%b vld1=%b, want 0 0", resp0_valid, resp1_valid);
    end
    resp0_ready = 1'b0;
  endtask

  task automatic test_round_robin;
    reset = 1'b1;
    req0_a = 16'h1234; req0_b = 16'h0F0F; req0_func = 4'h2;
    req1_a = 16'h00F0; req1_b = 16'h0F00; req1_func = 4'h3;
    req0_valid = 1'b1; req1_valid = 1'b1;
    resp0_ready = 1'b1; resp1_ready = 1'b1;
    tick();
    tick();
    tests_run++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL rr_in_reset: rdy0=%b rdy1=%b, want 0 0", req0_ready, req1_ready);
    end
    reset = 1'b0;
    #1;
    tests_run++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL rr_first: rdy0=%b rdy1=%b, want 1 0", req0_ready, req1_ready);
    end
    tick();
    req0_valid = 1'b0;
    #1;
    tests_run++;
    if (req1_ready !== 1'b0 || alu_a !== 16'h1234 || alu_func !== 4'h2) begin
      tests_failed++;
      $display("FAIL rr_exec0: rdy1=%b a=%h f=%h, want 0 1234 2", req1_ready, alu_a, alu_func);
    end
    tick();
    tests_run++;
    if (resp0_valid !== 1'b1 || resp1_valid !== 1'b0 || resp0_c !== 16'h0204) begin
      tests_failed++;
      $display("FAIL rr_resp0: vld0=%b vld1=%b c=%h, want 1 0 0204", resp0_valid, resp1_valid, resp0_c);
    end
    tick();
    req0_valid = 1'b1;
    #1;
    tests_run++;
    if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL rr_second: rdy0=%b rdy1=%b, want 0 1", req0_ready, req1_ready);
    end
    tick();
    req1_valid = 1'b0;
    tick();
    tests_run++;
    if (resp1_valid !== 1'b1 || resp0_valid !== 1'b0 || resp1_c !== 16'h0FF0 || resp1_ovf !== 1'b0) begin
      tests_failed++;
      $display("FAIL rr_resp1: vld0=%b vld1=%b c=%h ovf=%b, want 0 1 0ff0 0",
               resp0_valid, resp1_valid, resp1_c, resp1_ovf);
    end
    tick();
    req1_valid = 1'b1;
    #1;
    tests_run++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL rr_third: rdy0=%b rdy1=%b, want 1 0", req0_ready, req1_ready);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    resp0_ready = 1'b0; resp1_ready = 1'b0;
    #1;
  endtask

  task automatic test_backpressure;
    req1_a = 16'h7FFF; req1_b = 16'h0001; req1_func = 4'h0;
    req1_valid = 1'b1; resp1_ready = 1'b0;
    #1;
    tests_run++;
    if (req1_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_accept: rdy1=%b, want 1", req1_ready);
    end
    tick();
    req1_a = 16'hAAAA; req1_b = 16'h5555; req1_func = 4'h3;
    req0_valid = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      tests_run++;
      if (resp1_valid !== 1'b1 || resp0_valid !== 1'b0 || resp1_c !== 16'h8000 ||
          resp1_ovf !== 1'b1 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL bp_hold cyc%0d: vld=%b%b c=%h ovf=%b rdy=%b%b, want vld 01 c 8000 ovf 1 rdy 00",
                 i, resp0_valid, resp1_valid, resp1_c, resp1_ovf, req0_ready, req1_ready);
      end
      req1_a = req1_a + 16'h0101;
      tick();
    end
    resp1_ready = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    tests_run++;
    if (resp1_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_release: vld1=%b, want 0", resp1_valid);
    end
    resp1_ready = 1'b0;
  endtask

  task automatic test_reset_in_exec;
    bit got;
    req0_a = 16'h0005; req0_b = 16'h0006; req0_func = 4'h0;
    req0_valid = 1'b1; resp0_ready = 1'b1;
    tick();
    reset = 1'b1;
    req0_valid = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    tests_run++;
    if (alu_a !== 16'h0000 || alu_b !== 16'h0000) begin
      tests_failed++;
      $display("FAIL rst_exec_ops: a=%h b=%h, want 0000 0000", alu_a, alu_b);
    end
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (resp0_valid !== 1'b0 || resp1_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL rst_exec_noresp cyc%0d: vld0=%b vld1=%b, want 0 0", i, resp0_valid, resp1_valid);
      end
      tick();
    end
    req0_a = 16'h0009; req0_b = 16'h0001;
    req0_valid = 1'b1;
    #1;
    tests_run++;
    if (req0_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_exec_idle: rdy0=%b, want 1", req0_ready);
    end
    tick();
    req0_valid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 6 && !got; i++) begin
      if (resp0_valid === 1'b1) got = 1'b1;
      else tick();
    end
    tests_run++;
    if (!got || resp0_c !== 16'h000A) begin
      tests_failed++;
      $display("FAIL rst_exec_next: seen=%b c=%h, want 1 000a", got, resp0_c);
    end
    tick();
    resp0_ready = 1'b0;
  endtask

`ifdef ALU_SHARE_ARBITER_STATS_EN
  task automatic do_op(input bit id, input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] f, output logic [15:0] c, output bit ok);
    bit got;
    ok = 1'b0;
    c  = 16'h0000;
    if (id) begin
      req1_a = a; req1_b = b; req1_func = f; req1_valid = 1'b1; resp1_ready = 1'b1;
    end else begin
      req0_a = a; req0_b = b; req0_func = f; req0_valid = 1'b1; resp0_ready = 1'b1;
    end
    #1;
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      if ((id ? req1_ready : req0_ready) === 1'b1) got = 1'b1;
      else tick();
    end
    if (got) begin
      tick();
      req0_valid = 1'b0; req1_valid = 1'b0;
      got = 1'b0;
      for (int i = 0; i < 8 && !got; i++) begin
        if ((id ? resp1_valid : resp0_valid) === 1'b1) got = 1'b1;
        else tick();
      end
      if (got) begin
        c  = id ? resp1_c : resp0_c;
        ok = 1'b1;
        tick();
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    resp0_ready = 1'b0; resp1_ready = 1'b0;
    #1;
  endtask

  task automatic test_stats;
    logic [15:0] c;
    bit ok;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    tests_run++;
    if (grant_cnt0 !== 16'h0 || grant_cnt1 !== 16'h0 || ovf_cnt !== 16'h0) begin
      tests_failed++;
      $display("FAIL stats_reset: g0=%0d g1=%0d ovf=%0d, want 0 0 0", grant_cnt0, grant_cnt1, ovf_cnt);
    end
    do_op(1'b0, 16'h0001, 16'h0001, 4'h0, c, ok);
    tests_run++;
    if (!ok || c !== 16'h0002) begin tests_failed++; $display("FAIL stats_op1: ok=%b c=%h, want 1 0002", ok, c); end
    do_op(1'b1, 16'h7FFF, 16'h7FFF, 4'h0, c, ok);
    tests_run++;
    if (!ok || c !== 16'hFFFE) begin tests_failed++; $display("FAIL stats_op2: ok=%b c=%h, want 1 fffe", ok, c); end
    do_op(1'b0, 16'h0002, 16'h0002, 4'h0, c, ok);
    tests_run++;
    if (!ok || c !== 16'h0004) begin tests_failed++; $display("FAIL stats_op3: ok=%b c=%h, want 1 0004", ok, c); end
    do_op(1'b1, 16'h0005, 16'h0005, 4'h0, c, ok);
    tests_run++;
    if (!ok || c !== 16'h000A) begin tests_failed++; $display("FAIL stats_op4: ok=%b c=%h, want 1 000a", ok, c); end
    do_op(1'b0, 16'h0003, 16'h0003, 4'h0, c, ok);
    tests_run++;
    if (!ok || c !== 16'h0006) begin tests_failed++; $display("FAIL stats_op5: ok=%b c=%h, want 1 0006", ok, c); end
    tests_run++;
    if (grant_cnt0 !== 16'd3 || grant_cnt1 !== 16'd2 || ovf_cnt !== 16'd1) begin
      tests_failed++;
      $display("FAIL stats_counts: g0=%0d g1=%0d ovf=%0d, want 3 2 1", grant_cnt0, grant_cnt1, ovf_cnt);
    end
  endtask
`endif

  initial begin
    reset = 1'b1;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_func = '0; resp0_ready = 1'b0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_func = '0; resp1_ready = 1'b0;
    test_reset();
    test_single_add();
    test_round_robin();
    test_backpressure();
    test_reset_in_exec();
`ifdef ALU_SHARE_ARBITER_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one combinational ALU instance (16-bit, 4-bit FuncCode, C + OverflowFlag outputs) between two requesters (req0, req1).
- Arbitrates round-robin, latches the winner's operands, drives the ALU for one execute cycle, registers the result, and returns it with a valid/ready response handshake.
- Sits between the datapath/controller front ends and the ALU; the ALU itself stays purely combinational.

Parameters:
- DATA_WIDTH, 16, operand/result width; must match the ALU's data_width.
- FUNC_WIDTH, 4, function code width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_a, req0_b  in  DATA_WIDTH  requester 0 operands.
- req0_func  in  FUNC_WIDTH  requester 0 function code.
- resp0_valid  out  1  result for requester 0 available.
- resp0_ready  in  1  requester 0 takes the result.
- resp0_c  out  DATA_WIDTH  result.
- resp0_ovf  out  1  overflow flag of the result.
- req1_* / resp1_*: identical set for requester 1.
- alu_a, alu_b  out  DATA_WIDTH  to ALU A, B.
- alu_func  out  FUNC_WIDTH  to ALU FuncCode.
- alu_c  in  DATA_WIDTH  from ALU C.
- alu_ovf  in  1  from ALU OverflowFlag.

Behaviour:
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- IDLE:
  - reqN_ready is combinational and asserted only for the arbitration winner.
  - Winner is the only valid requester. If both are valid, the winner is the requester not granted last (last_grant).
  - On handshake (valid && ready), latch a/b/func into operand registers, record owner, set last_grant = owner, go to EXEC.
  - No handshake: stay in IDLE.
- EXEC (exactly 1 cycle):
  - alu_a/alu_b/alu_func always reflect the operand registers.
  - At the end of EXEC, register alu_c and alu_ovf into the result registers, then go to RESP.
- RESP:
  - respN_valid = 1 for the owner only. The other resp valid stays 0.
  - Hold until respN_ready = 1, then return to IDLE.
  - Both req ready outputs are 0 in EXEC and RESP.
- Latency: accept at cycle N; resp valid at N+2. Peak throughput is 1 op per 3 cycles, because there is no accept in RESP.
- Response data: resp0_c/resp1_c and resp0_ovf/resp1_ovf all drive the shared result registers. Data is meaningful only while the matching valid is high.
- Result is stable for the whole RESP stall, even if req inputs change.
- Reset values:
  - All ready and resp valid outputs 0.
  - Result registers 0; operand registers 0, so alu_a/alu_b/alu_func = 0.
  - last_grant = 1, so req0 wins the first contested arbitration.
- Reset mid-operation (EXEC or RESP):
  - The operation is dropped and no response is produced.
  - The FSM returns to IDLE on the next edge.
- Requester drops valid without a handshake: no effect; arbitration re-evaluates every IDLE cycle.
- Same requester has a new op while its response is pending: it is not accepted until RESP completes.
- Width rules: no arithmetic in this block; values pass through unmodified.

Optional Feature:
- Macro: ALU_SHARE_ARBITER_STATS_EN.
- With the macro defined:
  - Extra outputs grant_cnt0 and grant_cnt1, each 16 bits.
  - Each counter increments on its requester's accept handshake and saturates at 16'hFFFF.
  - Extra output ovf_cnt, 16 bits, increments when a result captured in EXEC has alu_ovf = 1, saturating.
  - All counters clear on reset.
- Without the macro: these ports and registers do not exist; core behaviour is identical.

Decomposition:
- Shared package/header holds:
  - FSM state encodings (ST_IDLE = 2'd0, ST_EXEC = 2'd1, ST_RESP = 2'd2).
  - ALU function code constants, shared with the ALU and the control unit.
  - DATA_WIDTH/FUNC_WIDTH defaults.
- One sub-module: rr_arb2.
  - Combinational 2-way round-robin: inputs valid0, valid1, last_grant; outputs gnt0, gnt1, gnt_id.
- The ALU is instantiated by the parent, not inside this block.

Test Plan:
- Reset, then idle: all ready/valid = 0, alu_a = alu_b = 0, alu_func = 0; no output changes over 10 cycles.
- req0 only, a = 16'h0003, b = 16'h0004, ADD, resp0_ready = 1: req0_ready at cycle N, resp0_valid at N+2 with c = 16'h0007, ovf = 0; resp1_valid stays 0.
- req0 and req1 both valid from reset: req0 is granted first, req1 second. After req1 completes, a re-asserted req0 wins.
- req1 ADD 16'h7FFF + 16'h0001, resp1_ready held 0 for 5 cycles: resp1_valid held with c = 16'h8000, ovf = 1 stable throughout; no new accepts.
- Reset asserted in EXEC: no resp valid ever appears for that op; FSM is in IDLE next cycle, and the next request completes normally.
- With ALU_SHARE_ARBITER_STATS_EN: 3 req0 ops + 2 req1 ops (one overflowing) -> grant_cnt0 = 3, grant_cnt1 = 2, ovf_cnt = 1.
